taxi_axil_csr_bridge: RTL and testbench

TAXI_AXIL_CSR_BRIDGE -- requirements
Module: taxi_axil_csr_bridge

---
 rtl/taxi_axil_pkg.sv | 15 +
 rtl/taxi_axil_if.sv | 68 ++++++
 rtl/taxi_axil_csr_bridge.sv | 189 ++++++++++++++++++
 tb/tb_taxi_axil_csr_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_axil_pkg.sv
// Shared AXI4-lite definitions: channel FSM states
// and response encodings used by the CSR bridge.
package taxi_axil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } axil_fsm_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-lite bundle with separate read/write
// slave and master views.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int USER_W = 1
) ();

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic [USER_W-1:0] awuser;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [USER_W-1:0] wuser;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [USER_W-1:0] ruser;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awprot, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wuser, wvalid,
    output wready,
    output bresp, buser, bvalid,
    input  bready
  );

  modport rd_slv (
    input  araddr, arprot, aruser, arvalid,
    output arready,
    output rdata, rresp, ruser, rvalid,
    input  rready
  );

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wuser, wvalid,
    input  wready,
    input  bresp, buser, bvalid,
    output bready
  );

  modport rd_mst (
    output araddr, arprot, aruser, arvalid,
    input  arready,
    input  rdata, rresp, ruser, rvalid,
    output rready
  );

endinterface

// File: rtl/taxi_axil_csr_bridge.sv
// AXI4-lite slave to simple CSR strobe/ack bus,
// independent read and write FSMs with ack timeout.
module taxi_axil_csr_bridge
  import taxi_axil_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  taxi_axil_if.wr_slv s_axil_wr,
  taxi_axil_if.rd_slv s_axil_rd,
  output logic [s_axil_wr.ADDR_W-1:0] reg_wr_addr,
  output logic [s_axil_wr.DATA_W-1:0] reg_wr_data,
  output logic [s_axil_wr.STRB_W-1:0] reg_wr_strb,
  output logic                        reg_wr_en,
  input  logic                        reg_wr_ack,
  output logic [s_axil_rd.ADDR_W-1:0] reg_rd_addr,
  output logic                        reg_rd_en,
  input  logic [s_axil_rd.DATA_W-1:0] reg_rd_data,
  input  logic                        reg_rd_ack
);

  localparam int DATA_W = s_axil_wr.DATA_W;
  localparam int ADDR_W = s_axil_wr.ADDR_W;
  localparam int STRB_W = s_axil_wr.STRB_W;
  localparam int TO_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] A_MASK =
    ~ADDR_W'(STRB_W - 1);

  axil_fsm_t wr_state, wr_next;
  axil_fsm_t rd_state, rd_next;

  logic              live;
  logic              aw_got, w_got;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [1:0]        bresp;
  logic [TO_W-1:0]   wr_cnt;
  logic              wr_done;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [TO_W-1:0]   rd_cnt;
  logic              rd_done;

  logic aw_hs, w_hs, ar_hs;
  logic wr_expire, rd_expire;

  assign aw_hs = s_axil_wr.awvalid && s_axil_wr.awready;
  assign w_hs  = s_axil_wr.wvalid && s_axil_wr.wready;
  assign ar_hs = s_axil_rd.arvalid && s_axil_rd.arready;

  assign wr_expire = (TIMEOUT > 0) &&
    (wr_cnt == TO_W'(TIMEOUT - 1));
  assign rd_expire = (TIMEOUT > 0) &&
    (rd_cnt == TO_W'(TIMEOUT - 1));

  // readies held off until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_comb begin
    wr_next = wr_state;
    wr_done = 1'b0;
    unique case (wr_state)
      ST_IDLE:
        if ((aw_got || aw_hs) && (w_got || w_hs))
          wr_next = ST_ISSUE;
      ST_ISSUE: begin
        wr_next = reg_wr_ack ? ST_RESP : ST_WAIT;
        wr_done = reg_wr_ack;
      end
      ST_WAIT:
        if (reg_wr_ack || wr_expire) begin
          wr_next = ST_RESP;
          wr_done = 1'b1;
        end
      ST_RESP:
        if (s_axil_wr.bready) wr_next = ST_IDLE;
      default: wr_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= ST_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_strb  <= '0;
      bresp    <= '0;
      wr_cnt   <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_got  <= 1'b1;
        wr_addr <= s_axil_wr.awaddr & A_MASK;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wr_data <= s_axil_wr.wdata;
        wr_strb <= s_axil_wr.wstrb;
      end
      if (wr_state == ST_IDLE && wr_next == ST_ISSUE) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        wr_cnt <= '0;
      end else if (wr_state == ST_WAIT &&
                   wr_cnt < TO_W'(TIMEOUT)) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (wr_done)
        bresp <= reg_wr_ack ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    rd_next = rd_state;
    rd_done = 1'b0;
    unique case (rd_state)
      ST_IDLE:
        if (ar_hs) rd_next = ST_ISSUE;
      ST_ISSUE: begin
        rd_next = reg_rd_ack ? ST_RESP : ST_WAIT;
        rd_done = reg_rd_ack;
      end
      ST_WAIT:
        if (reg_rd_ack || rd_expire) begin
          rd_next = ST_RESP;
          rd_done = 1'b1;
        end
      ST_RESP:
        if (s_axil_rd.rready) rd_next = ST_IDLE;
      default: rd_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= ST_IDLE;
      rd_addr  <= '0;
      rdata    <= '0;
      rresp    <= '0;
      rd_cnt   <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rd_addr <= s_axil_rd.araddr & A_MASK;
        rd_cnt  <= '0;
      end else if (rd_state == ST_WAIT &&
                   rd_cnt < TO_W'(TIMEOUT)) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (rd_done) begin
        rdata <= reg_rd_ack ? reg_rd_data : '0;
        rresp <= reg_rd_ack ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axil_wr.awready =
    live && wr_state == ST_IDLE && !aw_got;
  assign s_axil_wr.wready =
    live && wr_state == ST_IDLE && !w_got;
  assign s_axil_wr.bvalid = wr_state == ST_RESP;
  assign s_axil_wr.bresp  = bresp;
  assign s_axil_wr.buser  = '0;

  assign s_axil_rd.arready =
    live && rd_state == ST_IDLE;
  assign s_axil_rd.rvalid = rd_state == ST_RESP;
  assign s_axil_rd.rdata  = rdata;
  assign s_axil_rd.rresp  = rresp;
  assign s_axil_rd.ruser  = '0;

  assign reg_wr_en   = wr_state == ST_ISSUE;
  assign reg_wr_addr = wr_addr;
  assign reg_wr_data = wr_data;
  assign reg_wr_strb = wr_strb;
  assign reg_rd_en   = rd_state == ST_ISSUE;
  assign reg_rd_addr = rd_addr;

endmodule

// File: tb/tb_taxi_axil_csr_bridge.sv
// Directed bench for the AXI4-lite CSR bridge.
// Drives AXI and register side by hand per cycle.
`timescale 1ns/1ps
module tb_taxi_axil_csr_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] reg_wr_addr, reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_wr_ack;
  logic [31:0] reg_rd_addr, reg_rd_data;
  logic        reg_rd_en, reg_rd_ack;

  int checks = 0;
  int fails  = 0;
  int wr_en_n = 0, rd_en_n = 0;
  int b_n = 0, r_n = 0;
  int s_we, s_re, s_b, s_r;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

  taxi_axil_csr_bridge #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axil_wr   (axil),
    .s_axil_rd   (axil),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_ack  (reg_wr_ack),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .reg_rd_ack  (reg_rd_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) wr_en_n <= wr_en_n + 1;
      if (reg_rd_en) rd_en_n <= rd_en_n + 1;
      if (axil.bvalid && axil.bready) b_n <= b_n + 1;
      if (axil.rvalid && axil.rready) r_n <= r_n + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_we = wr_en_n;
    s_re = rd_en_n;
    s_b  = b_n;
    s_r  = r_n;
  endtask

  task automatic aw_w(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s);
    axil.awaddr  = a;
    axil.awvalid = 1'b1;
    axil.wdata   = d;
    axil.wstrb   = s;
    axil.wvalid  = 1'b1;
  endtask

  initial begin
    axil.awaddr = '0; axil.awprot = '0;
    axil.awuser = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0;
    axil.wuser = '0; axil.wvalid = 1'b0;
    axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0;
    axil.aruser = '0; axil.arvalid = 1'b0;
    axil.rready = 1'b0;
    reg_wr_ack = 1'b0; reg_rd_ack = 1'b0;
    reg_rd_data = '0;

    #1;
    check("rst_awready", axil.awready, 0);
    check("rst_arready", axil.arready, 0);
    check("rst_bvalid", axil.bvalid, 0);
    check("rst_rvalid", axil.rvalid, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_rd_en", reg_rd_en, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rel_awready_pre", axil.awready, 0);
    tick();
    check("rel_awready", axil.awready, 1);
    check("rel_wready", axil.wready, 1);
    check("rel_arready", axil.arready, 1);

    // same-cycle AW+W, same-cycle ack
    snap();
    axil.bready = 1'b1;
    aw_w(32'h13, 32'hDEADBEEF, 4'hF);
    tick();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    check("t1_en", reg_wr_en, 1);
    check("t1_addr", reg_wr_addr, 32'h10);
    check("t1_data", reg_wr_data, 32'hDEADBEEF);
    check("t1_strb", reg_wr_strb, 4'hF);
    check("t1_awready_issue", axil.awready, 0);
    check("t1_bvalid_early", axil.bvalid, 0);
    reg_wr_ack = 1'b1;
    tick();
    reg_wr_ack = 1'b0;
    check("t1_en_off", reg_wr_en, 0);
    check("t1_bvalid", axil.bvalid, 1);
    check("t1_bresp", axil.bresp, 2'b00);
    check("t1_buser", axil.buser, 0);
    check("t1_awready_resp", axil.awready, 0);
    tick();
    check("t1_bvalid_done", axil.bvalid, 0);
    check("t1_awready_next", axil.awready, 1);
    check("t1_en_pulses", wr_en_n - s_we, 1);
    check("t1_b_beats", b_n - s_b, 1);

    // W three cycles ahead of AW, ack two cycles after en
    snap();
    axil.wdata = 32'h0000_00A5; axil.wstrb = 4'h1;
    axil.wvalid = 1'b1;
    tick();
    axil.wvalid = 1'b0;
    check("t2_wready_held", axil.wready, 0);
    check("t2_awready", axil.awready, 1);
    tick(); tick();
    check("t2_no_en", wr_en_n - s_we, 0);
    axil.awaddr = 32'h27; axil.awvalid = 1'b1;
    tick();
    axil.awvalid = 1'b0;
    check("t2_en", reg_wr_en, 1);
    check("t2_addr", reg_wr_addr, 32'h24);
    check("t2_data", reg_wr_data, 32'hA5);
    check("t2_strb", reg_wr_strb, 4'h1);
    tick(); tick();
    reg_wr_ack = 1'b1;
    tick();
    reg_wr_ack = 1'b0;
    check("t2_bvalid", axil.bvalid, 1);
    check("t2_bresp", axil.bresp, 2'b00);
    tick();
    check("t2_en_pulses", wr_en_n - s_we, 1);
    check("t2_b_beats", b_n - s_b, 1);

    // read with back-pressured R channel
    snap();
    axil.araddr = 32'h4; axil.arvalid = 1'b1;
    tick();
    axil.arvalid = 1'b0;
    check("t3_rd_en", reg_rd_en, 1);
    check("t3_rd_addr", reg_rd_addr, 32'h4);
    check("t3_arready", axil.arready, 0);
    reg_rd_ack = 1'b1; reg_rd_data = 32'h12345678;
    tick();
    reg_rd_ack = 1'b0; reg_rd_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      check("t3_rvalid", axil.rvalid, 1);
      check("t3_rdata", axil.rdata, 32'h12345678);
      tick();
    end
    check("t3_rresp", axil.rresp, 2'b00);
    check("t3_ruser", axil.ruser, 0);
    axil.rready = 1'b1;
    tick();
    axil.rready = 1'b0;
    check("t3_rvalid_done", axil.rvalid, 0);
    check("t3_r_beats", r_n - s_r, 1);
    check("t3_rd_pulses", rd_en_n - s_re, 1);

    // write timeout, late ack ignored
    snap();
    axil.bready = 1'b0;
    aw_w(32'h40, 32'h1, 4'hF);
    tick();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    check("t4_en", reg_wr_en, 1);
    repeat (16) tick();
    check("t4_bvalid_16", axil.bvalid, 0);
    tick();
    check("t4_bvalid_17", axil.bvalid, 1);
    check("t4_bresp", axil.bresp, 2'b10);
    axil.bready = 1'b1;
    tick();
    check("t4_bvalid_done", axil.bvalid, 0);
    tick(); tick();
    reg_wr_ack = 1'b1;
    tick();
    reg_wr_ack = 1'b0;
    check("t4_late_ack_b", axil.bvalid, 0);
    check("t4_late_ack_rdy", axil.awready, 1);
    check("t4_en_pulses", wr_en_n - s_we, 1);
    check("t4_b_beats", b_n - s_b, 1);

    // read timeout
    snap();
    axil.araddr = 32'h1F; axil.arvalid = 1'b1;
    reg_rd_data = 32'hAAAA5555;
    tick();
    axil.arvalid = 1'b0;
    check("t5_rd_addr", reg_rd_addr, 32'h1C);
    repeat (16) tick();
    check("t5_rvalid_16", axil.rvalid, 0);
    tick();
    check("t5_rvalid", axil.rvalid, 1);
    check("t5_rresp", axil.rresp, 2'b10);
    check("t5_rdata", axil.rdata, 32'h0);
    axil.rready = 1'b1;
    tick();
    check("t5_r_beats", r_n - s_r, 1);

    // concurrent write and read
    snap();
    aw_w(32'h8, 32'hCAFEF00D, 4'h3);
    axil.araddr = 32'hC; axil.arvalid = 1'b1;
    tick();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    axil.arvalid = 1'b0;
    check("t6_wr_en", reg_wr_en, 1);
    check("t6_rd_en", reg_rd_en, 1);
    check("t6_wr_addr", reg_wr_addr, 32'h8);
    check("t6_rd_addr", reg_rd_addr, 32'hC);
    check("t6_wr_data", reg_wr_data, 32'hCAFEF00D);
    check("t6_wr_strb", reg_wr_strb, 4'h3);
    reg_wr_ack = 1'b1; reg_rd_ack = 1'b1;
    reg_rd_data = 32'h0BADC0DE;
    tick();
    reg_wr_ack = 1'b0; reg_rd_ack = 1'b0;
    check("t6_bvalid", axil.bvalid, 1);
    check("t6_bresp", axil.bresp, 2'b00);
    check("t6_rvalid", axil.rvalid, 1);
    check("t6_rresp", axil.rresp, 2'b00);
    check("t6_rdata", axil.rdata, 32'h0BADC0DE);
    tick();
    axil.rready = 1'b0;
    check("t6_b_beats", b_n - s_b, 1);
    check("t6_r_beats", r_n - s_r, 1);

    // reset while waiting for ack
    aw_w(32'h30, 32'h55, 4'hF);
    tick();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    tick();
    check("t7_wait_en", reg_wr_en, 0);
    rst_n = 1'b0;
    #1;
    check("t7_awready", axil.awready, 0);
    check("t7_wready", axil.wready, 0);
    check("t7_arready", axil.arready, 0);
    check("t7_bvalid", axil.bvalid, 0);
    check("t7_wr_addr", reg_wr_addr, 0);
    check("t7_wr_data", reg_wr_data, 0);
    check("t7_wr_strb", reg_wr_strb, 0);
    check("t7_rdata", axil.rdata, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    #1 check("t7_awready_pre", axil.awready, 0);
    tick();
    check("t7_awready_post", axil.awready, 1);
    reg_wr_ack = 1'b1;
    repeat (20) tick();
    reg_wr_ack = 1'b0;
    check("t7_no_b", b_n - s_b, 0);
    check("t7_no_en", wr_en_n - s_we, 0);
    check("t7_bvalid_end", axil.bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
